// File: rtl/debug_pkg.sv
// Shared definitions for the MCU debug controller: command codes, FSM states
// and the constants used to build reply words.
package debug_pkg;

  typedef enum logic [3:0] {
    CMD_NOP       = 4'h0,
    CMD_PAUSE     = 4'h1,
    CMD_RESUME    = 4'h2,
    CMD_STATUS    = 4'h3,
    CMD_MCU_RESET = 4'h4,
    CMD_MEM_RD    = 4'h5,
    CMD_MEM_WR    = 4'h6,
    CMD_REG_RD    = 4'h7,
    CMD_REG_WR    = 4'h8,
    CMD_BP_SET    = 4'h9,
    CMD_BP_CLR    = 4'hA
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_PAUSE_WAIT,
    S_MEM_WAIT,
    S_REG_CAP,
    S_DONE
  } state_e;

  // Reply word returned when a memory access never completes.
  localparam logic [31:0] DBG_ERR_WORD    = 32'hDEAD_DEAD;
  localparam int          DBG_MEM_TIMEOUT = 255;

endpackage

// File: rtl/dbg_bp_unit.sv
// PC breakpoint slots: address registers, valid bits and PC comparators.
// Only present when DBG_BREAKPOINT_EN is defined.
module dbg_bp_unit #(
  parameter int NUM_BP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_en,
  input  logic        clr_en,
  input  logic        clr_all,
  input  logic [2:0]  idx,
  input  logic [31:0] addr,
  input  logic [31:0] pc,
  output logic        hit
);

  logic [NUM_BP-1:0][31:0] slot_q, slot_d;
  logic [NUM_BP-1:0]       valid_q, valid_d;

  // Slot write/invalidate; the caller guarantees idx is in range.
  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    for (int i = 0; i < NUM_BP; i++) begin
      if (set_en && idx == 3'(i)) begin
        slot_d[i]  = addr;
        valid_d[i] = 1'b1;
      end
      if (clr_en && (clr_all || idx == 3'(i))) valid_d[i] = 1'b0;
    end
  end

  // Slot state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      valid_q <= '0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

  // Any valid slot matching the current PC.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++)
      if (valid_q[i] && slot_q[i] == pc) hit = 1'b1;
  end

endmodule

// File: rtl/mcu_debug_controller.sv
// Debug command executor between the serial front end and the MCU debug ports.
// Optional PC breakpoints are compiled in with DBG_BREAKPOINT_EN.
module mcu_debug_controller
  import debug_pkg::*;
#(
  parameter int MEM_TIMEOUT = DBG_MEM_TIMEOUT,
  parameter int NUM_BP      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cmd,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  input  logic        out_valid,
  output logic        ctrlr_busy,
  output logic [31:0] d_rd,
  output logic        error,
  output logic        mcu_pause,
  input  logic        mcu_paused,
  output logic        mcu_reset,
  input  logic [31:0] mcu_pc,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_rd,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [31:0] mem_dout,
  output logic [4:0]  reg_addr,
  output logic [31:0] reg_din,
  output logic        reg_we,
  input  logic [31:0] reg_dout
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [7:0] TO_SAT  = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  cmd_e        cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d, din_q, din_d;
  logic [31:0] res_q, res_d, d_rd_q, d_rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, rerr_q, rerr_d, err_q, err_d;
  logic        pause_q, pause_d;
  logic        exec, bp_hit;

`ifdef DBG_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d, bp_match, slot_ok, clr_all;
  assign bp_hit  = bp_hit_q;
  assign slot_ok = int'(din_q[2:0]) < NUM_BP;
  assign clr_all = din_q == 32'hFFFF_FFFF;

  dbg_bp_unit #(.NUM_BP(NUM_BP)) u_bp (
    .clk    (clk),
    .rst_n  (reset),
    .set_en (exec && cmd_q == CMD_BP_SET && slot_ok),
    .clr_en (exec && cmd_q == CMD_BP_CLR && (slot_ok || clr_all)),
    .clr_all(clr_all),
    .idx    (din_q[2:0]),
    .addr   (addr_q),
    .pc     (mcu_pc),
    .hit    (bp_match)
  );
`else
  logic unused_pc;
  localparam int unused_num_bp = NUM_BP;
  assign unused_pc = ^mcu_pc;
  assign bp_hit    = 1'b0;
`endif

  // Bus/port pulses are issued only from S_EXEC and only with the MCU halted.
  assign exec       = state_q == S_EXEC;
  assign mem_rd     = exec && cmd_q == CMD_MEM_RD && mcu_paused;
  assign mem_we     = exec && cmd_q == CMD_MEM_WR && mcu_paused;
  assign reg_we     = exec && cmd_q == CMD_REG_WR && mcu_paused;
  assign mcu_reset  = exec && cmd_q == CMD_MCU_RESET;
  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign reg_addr   = addr_q[4:0];
  assign reg_din    = din_q;
  assign mcu_pause  = pause_q;
  assign ctrlr_busy = busy_q;
  assign d_rd       = d_rd_q;
  assign error      = err_q;

  // Command FSM: result/error are staged in res/rerr and published in S_DONE.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    din_d   = din_q;
    res_d   = res_q;
    rerr_d  = rerr_q;
    d_rd_d  = d_rd_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    pause_d = pause_q;
`ifdef DBG_BREAKPOINT_EN
    bp_hit_d = bp_hit_q;
`endif
    case (state_q)
      S_IDLE: if (out_valid) begin
        cmd_d   = cmd_e'(cmd);
        addr_d  = addr;
        din_d   = d_in;
        busy_d  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_DONE;
        res_d   = '0;
        rerr_d  = 1'b0;
        cnt_d   = '0;
        case (cmd_q)
          CMD_NOP, CMD_MCU_RESET: ;
          CMD_PAUSE: begin
            pause_d = 1'b1;
            state_d = S_PAUSE_WAIT;
          end
          CMD_RESUME: begin
            pause_d = 1'b0;
`ifdef DBG_BREAKPOINT_EN
            bp_hit_d = 1'b0;
`endif
          end
          CMD_STATUS: res_d = {29'b0, bp_hit, pause_q, mcu_paused};
          CMD_MEM_RD, CMD_MEM_WR:
            if (!mcu_paused) rerr_d = 1'b1;
            else             state_d = S_MEM_WAIT;
          CMD_REG_RD:
            if (!mcu_paused) rerr_d = 1'b1;
            else             state_d = S_REG_CAP;
          CMD_REG_WR:
            if (!mcu_paused) rerr_d = 1'b1;
            else             res_d = din_q;
`ifdef DBG_BREAKPOINT_EN
          CMD_BP_SET: rerr_d = !slot_ok;
          CMD_BP_CLR: rerr_d = !(slot_ok || clr_all);
`endif
          default: rerr_d = 1'b1;
        endcase
      end
      S_PAUSE_WAIT:
        if (mcu_paused) begin
          res_d   = 32'd1;
          state_d = S_DONE;
        end else if (cnt_q >= TO_LAST) begin
          rerr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = (cnt_q == TO_SAT) ? cnt_q : cnt_q + 8'd1;
        end
      // An ack in the final counted cycle still wins over the timeout.
      S_MEM_WAIT:
        if (mem_ack) begin
          res_d   = (cmd_q == CMD_MEM_RD) ? mem_dout : din_q;
          state_d = S_DONE;
        end else if (cnt_q >= TO_LAST) begin
          rerr_d  = 1'b1;
          res_d   = DBG_ERR_WORD;
          state_d = S_DONE;
        end else begin
          cnt_d = (cnt_q == TO_SAT) ? cnt_q : cnt_q + 8'd1;
        end
      S_REG_CAP: begin
        res_d   = reg_dout;
        state_d = S_DONE;
      end
      S_DONE: begin
        d_rd_d  = res_q;
        err_d   = rerr_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef DBG_BREAKPOINT_EN
    // Breakpoint hit while running halts the MCU and latches the sticky flag.
    if (bp_match && !pause_q) begin
      pause_d  = 1'b1;
      bp_hit_d = 1'b1;
    end
`endif
  end

  // State registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      din_q   <= '0;
      res_q   <= '0;
      rerr_q  <= 1'b0;
      d_rd_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      pause_q <= 1'b0;
`ifdef DBG_BREAKPOINT_EN
      bp_hit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      res_q   <= res_d;
      rerr_q  <= rerr_d;
      d_rd_q  <= d_rd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      pause_q <= pause_d;
`ifdef DBG_BREAKPOINT_EN
      bp_hit_q <= bp_hit_d;
`endif
    end
  end

endmodule

// File: doc/mcu_debug_controller.md
# mcu_debug_controller

Executes one decoded debug command per transaction from the serial front end against the RISC-V MCU: pause/resume, status, MCU reset, memory word read/write, register read/write, optional PC breakpoints. Sits directly downstream of the serial driver, consuming `cmd`/`addr`/`d_in`/`out_valid` and returning `ctrlr_busy`/`d_rd`/`error`. It also drives the MCU's pause, reset, memory and register-file debug ports.

## Interface
- `MEM_TIMEOUT`, 255: max cycles waiting for `mem_ack` before error.
- `NUM_BP`, 4: breakpoint slots, 1–8 (used only with breakpoints compiled in).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `cmd` in 4: command code; `addr` in 32: address/operand; `d_in` in 32: write data; `out_valid` in 1: one-cycle command strobe.
- `ctrlr_busy` out 1: transaction in progress; `d_rd` out 32: reply word; `error` out 1: last command failed.
- `mcu_pause` out 1: hold MCU; `mcu_paused` in 1: MCU halted; `mcu_reset` out 1: one-cycle MCU reset; `mcu_pc` in 32: current PC.
- `mem_addr` out 32, `mem_din` out 32, `mem_rd` out 1, `mem_we` out 1: memory request (rd/we one-cycle pulses); `mem_ack` in 1, `mem_dout` in 32: response.
- `reg_addr` out 5, `reg_din` out 32, `reg_we` out 1: register port; `reg_dout` in 32: combinational read data.

## Operation
- Codes: 0x0 NOP, 0x1 PAUSE, 0x2 RESUME, 0x3 STATUS, 0x4 MCU_RESET, 0x5 MEM_RD, 0x6 MEM_WR, 0x7 REG_RD, 0x8 REG_WR, 0x9 BP_SET, 0xA BP_CLR; others illegal.
- FSM: S_IDLE → S_EXEC → (S_PAUSE_WAIT | S_MEM_WAIT | S_REG_CAP) → S_DONE → S_IDLE. Single-cycle commands go S_EXEC → S_DONE.
- `out_valid` is sampled only in S_IDLE; strobes in other states are ignored.
- NOP: `d_rd`=0. PAUSE: set `mcu_pause`, wait `mcu_paused`; `d_rd`=1; not paused within MEM_TIMEOUT → error. RESUME: clear `mcu_pause`, `d_rd`=0.
- STATUS: `d_rd`={29'b0, bp_hit, mcu_pause, mcu_paused}.
- MCU_RESET: pulse `mcu_reset` one cycle; `mcu_pause` unchanged; `d_rd`=0.
- MEM_RD/MEM_WR: `mem_addr`=addr, `mem_din`=d_in, pulse `mem_rd`/`mem_we`; wait `mem_ack`; `d_rd`=`mem_dout` (RD) or d_in (WR). Timeout → error, `d_rd`=0xDEAD_DEAD.
- REG_RD/REG_WR: `reg_addr`=addr[4:0]; REG_RD captures `reg_dout` one cycle later; REG_WR pulses `reg_we`, `d_rd`=d_in. addr[4:0]=0 write still issued, MCU ignores.
- MEM_*/REG_* while `mcu_paused`=0 → error, no bus activity, `d_rd`=0.
- Illegal code → error, `d_rd`=0.
- `error` and `d_rd` update only in S_DONE and hold until the next command completes.

## Timing
- Reset: all outputs 0, `mcu_pause`=0, `d_rd`=0, breakpoints invalid, FSM S_IDLE. Reset mid-transaction aborts; no pending pulses survive.
- `ctrlr_busy` is registered: rises the cycle after `out_valid` and falls in the cycle `d_rd`/`error` become valid, so the upstream sees busy before its own check.
- Single-cycle commands: busy high 2 cycles. REG_RD: 3. MEM: 2 + ack latency, at most MEM_TIMEOUT+2.
- Timeout counter: 8-bit saturating at MEM_TIMEOUT; `mem_ack` in the same cycle as expiry counts as success.
- Same-cycle `mem_ack` and issue pulse are ignored; ack is accepted from the cycle after the pulse.

## Configuration
- `DBG_BREAKPOINT_EN` defined:
  - BP_SET writes `addr` into slot d_in[2:0] (slot ≥ NUM_BP → error).
  - BP_CLR invalidates slot d_in[2:0]; d_in=0xFFFF_FFFF clears all.
  - Valid slot equal to `mcu_pc` while running → set `mcu_pause` and sticky `bp_hit`. RESUME clears `bp_hit`.
- Undefined: BP_SET/BP_CLR are illegal (error); `bp_hit` is tied 0; no compare logic.

## Structure
- `debug_pkg`: command enum, FSM state enum, `DBG_ERR_WORD`=0xDEAD_DEAD, default MEM_TIMEOUT.
- Sub-module `dbg_bp_unit`: slot registers, valid bits, PC comparators, hit output. Instantiated only under `DBG_BREAKPOINT_EN`.

## Test plan
- Reset, then STATUS with `mcu_paused`=0 → busy 2 cycles, `d_rd`=0, error=0.
- PAUSE, paused after 3 cycles; then MEM_WR addr 0x100 d_in 0xCAFE_F00D, ack at +2 → `mem_we` one pulse, `d_rd`=0xCAFE_F00D; MEM_RD 0x100 returns 0xCAFE_F00D.
- MEM_RD while paused, no ack → error=1 after 255 cycles, `d_rd`=0xDEAD_DEAD, busy falls.
- REG_RD addr 5 while running → error=1, no reg access; once paused → `d_rd`=`reg_dout`.
- Cmd 0xF → error=1. A following NOP → error=0.
- With `DBG_BREAKPOINT_EN`: BP_SET addr 0x40 slot 0, RESUME, drive `mcu_pc`=0x40 → `mcu_pause`=1, STATUS bit2=1.
